// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
package regfile_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        GNT_WB = 1'b0,
        GNT_LD = 1'b1
    } grant_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 3;
    localparam int DEF_MAX_BURST = 4;

    // Round-robin pick when both ports request: the port not granted last wins.
    function automatic grant_t rr_pick(input grant_t last_grant);
        return (last_grant == GNT_LD) ? GNT_WB : GNT_LD;
    endfunction

endpackage

// File: rtl/regfile_arb_stats.sv
// Saturating grant / forced-release counters for the write arbiter.
// Only instantiated when REGFILE_ARB_STATS_EN is defined.
module regfile_arb_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_xfer,
    input  logic        i_ld_xfer,
    input  logic        i_force_rel,
    output logic [15:0] o_wb_grant_cnt,
    output logic [15:0] o_ld_grant_cnt,
    output logic [7:0]  o_force_rel_cnt
);

    logic [15:0] r_wb_cnt;
    logic [15:0] r_ld_cnt;
    logic [7:0]  r_fr_cnt;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_cnt <= '0;
            r_ld_cnt <= '0;
            r_fr_cnt <= '0;
        end else begin
            if (i_wb_xfer && (r_wb_cnt != 16'hFFFF)) r_wb_cnt <= r_wb_cnt + 16'd1;
            if (i_ld_xfer && (r_ld_cnt != 16'hFFFF)) r_ld_cnt <= r_ld_cnt + 16'd1;
            if (i_force_rel && (r_fr_cnt != 8'hFF))  r_fr_cnt <= r_fr_cnt + 8'd1;
        end
    end

    assign o_wb_grant_cnt  = r_wb_cnt;
    assign o_ld_grant_cnt  = r_ld_cnt;
    assign o_force_rel_cnt = r_fr_cnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// pipeline writeback (wb) and the load/init unit (ld), with a capped,
// lockable burst mode for ld.
// Optional statistics counters: define REGFILE_ARB_STATS_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | round-robin between wb and ld, one write per cycle
// ARB_BURST | ld owns the port; wb stalled until unlock or cap reached
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_lock,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
`ifdef REGFILE_ARB_STATS_EN
    output logic [15:0]       wb_grant_cnt,
    output logic [15:0]       ld_grant_cnt,
    output logic [7:0]        force_rel_cnt,
`endif
    output logic              busy
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // A cap of one cycle means a locked ld write is already at its limit.
    localparam bit               BURST_OK = (MAX_BURST > 1);

    arb_state_t        r_state;
    grant_t            r_last_grant;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_busy;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_wb_ready;
    logic              w_ld_ready;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_cap;
    logic              w_unlock;

    // Grant decision: burst gives ld exclusive access, otherwise round-robin.
    always_comb begin
        w_wb_ready = 1'b0;
        w_ld_ready = 1'b0;
        if (!rst) begin
            if (r_state == ARB_BURST) begin
                w_ld_ready = ld_valid;
            end else if (wb_valid && ld_valid) begin
                if (rr_pick(r_last_grant) == GNT_WB) w_wb_ready = 1'b1;
                else                                 w_ld_ready = 1'b1;
            end else begin
                w_wb_ready = wb_valid;
                w_ld_ready = ld_valid;
            end
        end
    end

    // The count after this cycle reaching the cap ends the burst at this edge,
    // so ld holds the port for at most MAX_BURST cycles including entry.
    assign w_cnt_next = r_burst_cnt + CNT_ONE;
    assign w_cap      = (r_state == ARB_BURST) && (w_cnt_next == CNT_MAX);
    assign w_unlock   = w_ld_ready && !ld_lock;

    // FSM, round-robin history and the registered write command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GNT_LD;
            r_burst_cnt  <= '0;
            r_busy       <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_rf_we <= w_wb_ready || w_ld_ready;
            if (w_wb_ready) begin
                r_rf_waddr   <= wb_addr;
                r_rf_wdata   <= wb_data;
                r_last_grant <= GNT_WB;
            end else if (w_ld_ready) begin
                r_rf_waddr   <= ld_addr;
                r_rf_wdata   <= ld_data;
                r_last_grant <= GNT_LD;
            end

            case (r_state)
                ARB_IDLE: begin
                    if (w_ld_ready && ld_lock && BURST_OK) begin
                        r_state     <= ARB_BURST;
                        r_burst_cnt <= CNT_ONE;
                        r_busy      <= 1'b1;
                    end
                end
                ARB_BURST: begin
                    if (w_unlock || w_cap) begin
                        r_state      <= ARB_IDLE;
                        r_burst_cnt  <= '0;
                        r_busy       <= 1'b0;
                        r_last_grant <= GNT_LD;
                    end else begin
                        r_burst_cnt  <= w_cnt_next;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_burst_cnt <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign wb_ready = w_wb_ready;
    assign ld_ready = w_ld_ready;
    // A write command still in flight when rst rises is suppressed so the
    // register file never commits it on the following negedge.
    assign rf_we    = r_rf_we && !rst;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign busy     = r_busy;

`ifdef REGFILE_ARB_STATS_EN
    logic w_force_rel;

    // Forced release: burst ended by the cap, not by ld dropping its lock.
    // With a one-cycle cap, a locked ld write is released immediately.
    assign w_force_rel = (w_cap && !w_unlock) ||
                         (!BURST_OK && (r_state == ARB_IDLE) && w_ld_ready && ld_lock);

    regfile_arb_stats u_stats (
        .clk             (clk),
        .rst             (rst),
        .i_wb_xfer       (w_wb_ready),
        .i_ld_xfer       (w_ld_ready),
        .i_force_rel     (w_force_rel),
        .o_wb_grant_cnt  (wb_grant_cnt),
        .o_ld_grant_cnt  (ld_grant_cnt),
        .o_force_rel_cnt (force_rel_cnt)
    );
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a negedge-commit register file model.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid, wb_ready;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       ld_valid, ld_ready;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_lock;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] wb_grant_cnt, ld_grant_cnt;
    logic [7:0]  force_rel_cnt;
`endif

    logic [7:0] rf_mem [8];
    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_lock  (ld_lock),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
`ifdef REGFILE_ARB_STATS_EN
        .wb_grant_cnt  (wb_grant_cnt),
        .ld_grant_cnt  (ld_grant_cnt),
        .force_rel_cnt (force_rel_cnt),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [2:0] wa, input logic [7:0] wd,
                         input logic lv, input logic [2:0] la, input logic [7:0] ld,
                         input logic lk);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        ld_valid = lv; ld_addr = la; ld_data = ld; ld_lock = lk;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf_mem[i] = 8'h00;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state; readies held low during rst even with both valids up.
        drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02, 1'b0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_rf_we",    32'(rf_we),    32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        rst = 1'b0;
        idle_inputs();
        tick();

        // Single wb write, one-cycle latency.
        drive(1'b1, 3'd3, 8'h2D, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("t1_wb_ready", 32'(wb_ready), 32'd1);
        chk("t1_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        idle_inputs();
        chk("t1_rf_we",    32'(rf_we),    32'd1);
        chk("t1_rf_waddr", 32'(rf_waddr), 32'd3);
        chk("t1_rf_wdata", 32'(rf_wdata), 32'h2D);
        tick();
        chk("t1_rf_we_off", 32'(rf_we),     32'd0);
        chk("t1_hold_addr", 32'(rf_waddr),  32'd3);
        chk("t1_r3",        32'(rf_mem[3]), 32'h2D);

        // Both valid every cycle, no lock: wb, ld, wb, ld.
        do_reset();
        drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_wb_ready", 32'(wb_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_ld_ready", 32'(ld_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            chk("t2_rf_waddr", 32'(rf_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_rf_wdata", 32'(rf_wdata), (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle_inputs();

        // One wb-only write so ld wins the next contention.
        drive(1'b1, 3'd0, 8'hAA, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("pre3_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        idle_inputs();
`ifdef REGFILE_ARB_STATS_EN
        chk("st_wb_cnt", 32'(wb_grant_cnt), 32'd3);
        chk("st_ld_cnt", 32'(ld_grant_cnt), 32'd2);
`endif

        // Locked burst with both valid: ld for 4 cycles, forced release, then wb.
        drive(1'b1, 3'd1, 8'h55, 1'b1, 3'd6, 8'h66, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_ld_ready", 32'(ld_ready), 32'd1);
            chk("t3_wb_ready", 32'(wb_ready), 32'd0);
            tick();
            chk("t3_busy",     32'(busy),     (i < 3) ? 32'd1 : 32'd0);
            chk("t3_rf_waddr", 32'(rf_waddr), 32'd6);
        end
        chk("t3_rel_wb_ready", 32'(wb_ready), 32'd1);
        chk("t3_rel_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        idle_inputs();
        chk("t3_rel_rf_waddr", 32'(rf_waddr), 32'd1);
        chk("t3_rel_rf_wdata", 32'(rf_wdata), 32'h55);
`ifdef REGFILE_ARB_STATS_EN
        chk("st_force_rel", 32'(force_rel_cnt), 32'd1);
        chk("st_wb_cnt2",   32'(wb_grant_cnt),  32'd4);
        chk("st_ld_cnt2",   32'(ld_grant_cnt),  32'd6);
`endif

        // Burst entered, ld gaps two cycles, returns unlocked; wb stalled throughout.
        drive(1'b1, 3'd7, 8'h77, 1'b1, 3'd3, 8'h33, 1'b1);
        chk("t4_enter_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        chk("t4_busy", 32'(busy), 32'd1);
        drive(1'b1, 3'd7, 8'h77, 1'b0, 3'd3, 8'h33, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("t4_gap_wb_ready", 32'(wb_ready), 32'd0);
            chk("t4_gap_ld_ready", 32'(ld_ready), 32'd0);
            tick();
            chk("t4_gap_rf_we", 32'(rf_we), 32'd0);
        end
        drive(1'b1, 3'd7, 8'h77, 1'b1, 3'd4, 8'h44, 1'b0);
        chk("t4_ret_ld_ready", 32'(ld_ready), 32'd1);
        chk("t4_ret_wb_ready", 32'(wb_ready), 32'd0);
        tick();
        drive(1'b1, 3'd7, 8'h77, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("t4_exit_busy",   32'(busy),     32'd0);
        chk("t4_exit_rf_adr", 32'(rf_waddr), 32'd4);
        chk("t4_wb_ready",    32'(wb_ready), 32'd1);
        tick();
        idle_inputs();
        chk("t4_wb_rf_adr",   32'(rf_waddr), 32'd7);

        // Reset right after an accepted burst write to r5: write must be dropped.
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h11, 1'b1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h7F, 1'b1);
        chk("t5_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        rst = 1'b1;
        idle_inputs();
        chk("t5_rst_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("t5_after_rf_we", 32'(rf_we), 32'd0);
        chk("t5_after_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        drive(1'b1, 3'd2, 8'h20, 1'b0, 3'd0, 8'h00, 1'b0);
        chk("t5_idle_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        idle_inputs();
        tick();
        chk("t5_r5_untouched", 32'(rf_mem[5]), 32'h00);
        chk("t5_r2_written",   32'(rf_mem[2]), 32'h20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
